prim_lfsr_chk: RTL and testbench
================================

# prim_lfsr_chk

Self-synchronising checker for a Fibonacci XOR LFSR (PRBS) bit stream: the receive-side counterpart of the `prim_lfsr` generators. It fills its shadow state from the incoming data and locks after a run of correct predictions. Once locked, it flywheels on its own predictions and counts bit errors. It sits at the sink of link and loopback self-test paths and in formal benches, next to the generator it checks.

## Interface
- `LfsrDw`, default 7: LFSR width; range 3..64.
- `Taps`, default `7'h60`: feedback mask; the feedback bit is the XOR-reduce of `state & Taps` (x^7+x^6+1).
- `InDw`, default 1: bits per beat; range 1..`LfsrDw`.
- `LockCnt`, default 16: consecutive fully-matching beats needed to lock.
- `LossCnt`, default 4: consecutive beats containing an error that cause loss of lock.
- `CntDw`, default 16: width of the saturating error counter.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset. Asynchronous, active-low.
- `en_i`, input, 1: beat valid. The block ignores `data_i` and holds all state when low.
- `data_i`, input, `InDw`: stream bits. Bit `InDw-1` is the oldest bit in time.
- `clr_i`, input, 1: synchronous clear of `err_cnt_o`.
- `locked_o`, output, 1: the checker is in LOCKED.
- `err_o`, output, 1: one-cycle pulse; the previous beat had at least one mismatched bit while LOCKED.
- `err_cnt_o`, output, `CntDw`: saturating count of mismatched bits while LOCKED.

## Operation
- The generator model is fixed: per bit, `b = ^(s & Taps)` and `s <= {s[LfsrDw-2:0], b}`. The stream carries `b`.
- Each beat is processed serially in combinational logic, bit `InDw-1` first, then bit `InDw-2`, down to bit 0. For each bit:
  - `pred = ^(s & Taps)` is computed.
  - `pred` is compared with the received bit.
  - A shift-in bit is chosen per state and shifted into `s`.
- State machine (`state_e`): SEARCH, LOCKED. Reset state is SEARCH.
- SEARCH:
  - The received bits are shifted into `s`.
  - `fill_cnt` counts bits received, saturating at `LfsrDw`. A bit is compared only when `fill_cnt` equals `LfsrDw` before that bit is shifted.
  - A beat "matches" when every compared bit in it matches and it has at least one compared bit.
  - `match_cnt` increments on a matching beat and resets to 0 on any mismatch.
  - `match_cnt` is also held at 0 while `s` is all-zero, because the all-zero state is degenerate.
  - When `match_cnt` reaches `LockCnt`, the FSM goes to LOCKED. `match_cnt` and `loss_cnt` clear on that transition.
- LOCKED:
  - The predicted bits are shifted into `s` (flywheel), so an isolated bit error does not propagate.
  - The number of mismatched bits in the beat (popcount) is added to `err_cnt`. The sum saturates at `2^CntDw-1`.
  - `loss_cnt` increments on a beat with any error and resets to 0 on a clean beat.
  - When `loss_cnt` reaches `LossCnt`, the FSM goes to SEARCH. `fill_cnt` resets to 0 on that transition; `err_cnt` is kept.
- When `clr_i` and an error beat occur in the same cycle, the counter clears and then counts: `err_cnt` becomes the popcount of that beat.
- `clr_i` has no effect on the FSM.

## Timing
- Reset values: `locked_o` = 0, `err_o` = 0, `err_cnt_o` = 0, `s` = 0, and all internal counters = 0.
- All outputs are registered. Beat latency is 1 cycle: a beat sampled at edge N updates the outputs after edge N.
- `locked_o` rises after the edge that samples the beat completing `LockCnt`. That beat itself is not error-counted.
- `locked_o` falls after the edge that samples the `LossCnt`-th consecutive error beat. That beat is error-counted and raises `err_o`.
- When `en_i` is low, `err_o` is 0 in the next cycle and all other state holds.
- A reset asserted mid-operation returns the block to SEARCH immediately and asynchronously. Lock must then be reacquired from an empty fill.

## Structure
- Shared package `prim_lfsr_chk_pkg`: the `state_e` enum, the default-taps constant `PRBS7_TAPS` = `7'h60`, and parameter-legality checks.
- One natural sub-module, `prim_lfsr_chk_step`: combinational InDw-bit unroll.
  - Inputs: `s`, `data_i`, mode.
  - Outputs: `s` next value, mismatch vector, compare-valid vector.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Defaults with `InDw`=1 and a PRBS7 generator seeded `7'h01`, `en_i` high continuously → `locked_o` is 1 after the 23rd beat (7 fill + 16 match), `err_cnt_o` = 0, and `err_o` is never asserted.
- While locked, a single bit is flipped in one beat → exactly one `err_o` pulse, `err_cnt_o` = 1, `locked_o` stays 1, and no follow-on errors occur.
- All-zero input for 200 beats → `locked_o` stays 0 throughout.
- After lock, the input is replaced by the inverted stream → `locked_o` falls after the 4th error beat and `err_cnt_o` = 4. Restoring the true stream then relocks after 23 beats.
- `CntDw`=4 and 20 single-bit errors spaced 8 beats apart → `err_cnt_o` saturates at 15. Then `clr_i` together with an error beat → `err_cnt_o` = 1.
- `InDw`=4, `LfsrDw`=31, `Taps`=`31'h48000000` with `en_i` toggled randomly → the block locks, produces no errors, and holds all state in every idle cycle. `rst_ni` pulsed mid-lock → all outputs are 0 immediately, and the block relocks afterwards.

Source files
------------

// File: rtl/prim_lfsr_chk_pkg.sv
// prim_lfsr_chk_pkg: shared types and constants
// for the self-synchronising PRBS stream checker.
package prim_lfsr_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // x^7 + x^6 + 1
    localparam logic [6:0] PRBS7_TAPS = 7'h60;

    function automatic bit params_ok(
        input int lfsr_dw,
        input int in_dw,
        input int lock_cnt,
        input int loss_cnt,
        input int cnt_dw
    );
        return (lfsr_dw >= 3) && (lfsr_dw <= 64) &&
               (in_dw >= 1) && (in_dw <= lfsr_dw) &&
               (lock_cnt >= 1) && (loss_cnt >= 1) &&
               (cnt_dw >= 1);
    endfunction

endpackage

// File: rtl/prim_lfsr_chk_step.sv
// prim_lfsr_chk_step: one beat of the checker, unrolled
// bit by bit (oldest bit first) in combinational logic.
module prim_lfsr_chk_step
    import prim_lfsr_chk_pkg::*;
#(
    parameter int unsigned       LfsrDw = 7,
    parameter logic [LfsrDw-1:0] Taps   = PRBS7_TAPS,
    parameter int unsigned       InDw   = 1,
    localparam int unsigned      FillW  = $clog2(LfsrDw + 1)
) (
    input  logic [LfsrDw-1:0] i_s,
    input  logic [InDw-1:0]   i_data,
    input  state_e            i_mode,
    input  logic [FillW-1:0]  i_fill,
    output logic [LfsrDw-1:0] o_s,
    output logic [FillW-1:0]  o_fill,
    output logic [InDw-1:0]   o_mis,
    output logic [InDw-1:0]   o_vld
);

    // Predict, compare and shift each bit; LOCKED shifts
    // the prediction, SEARCH shifts the received bit.
    always_comb begin
        logic [LfsrDw-1:0] w_s;
        logic              w_pred;
        logic              w_in;
        int unsigned       w_fill;
        w_s    = i_s;
        w_fill = 32'(i_fill);
        w_pred = 1'b0;
        w_in   = 1'b0;
        o_mis  = '0;
        o_vld  = '0;
        for (int i = InDw - 1; i >= 0; i--) begin
            w_pred   = ^(w_s & Taps);
            o_vld[i] = (i_mode == LOCKED) || (w_fill == LfsrDw);
            o_mis[i] = o_vld[i] & (w_pred ^ i_data[i]);
            w_in     = (i_mode == LOCKED) ? w_pred : i_data[i];
            w_s      = {w_s[LfsrDw-2:0], w_in};
            if (w_fill < LfsrDw) begin
                w_fill = w_fill + 1;
            end
        end
        o_s    = w_s;
        o_fill = FillW'(w_fill);
    end

endmodule

// File: rtl/prim_lfsr_chk.sv
// prim_lfsr_chk: Fibonacci LFSR stream checker that locks
// onto the incoming PRBS and counts bit errors once locked.
module prim_lfsr_chk
    import prim_lfsr_chk_pkg::*;
#(
    parameter int unsigned       LfsrDw  = 7,
    parameter logic [LfsrDw-1:0] Taps    = PRBS7_TAPS,
    parameter int unsigned       InDw    = 1,
    parameter int unsigned       LockCnt = 16,
    parameter int unsigned       LossCnt = 4,
    parameter int unsigned       CntDw   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [InDw-1:0]  data_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CntDw-1:0] err_cnt_o
);

    localparam int unsigned FillW  = $clog2(LfsrDw + 1);
    localparam int unsigned MatchW = $clog2(LockCnt + 1);
    localparam int unsigned LossW  = $clog2(LossCnt + 1);
    localparam int unsigned PopW   = $clog2(InDw + 1);
    localparam int unsigned SumW   =
        ((CntDw > PopW) ? CntDw : PopW) + 1;

    if (!params_ok(LfsrDw, InDw, LockCnt, LossCnt, CntDw))
    begin : g_bad_params
        $error("prim_lfsr_chk: illegal parameters");
    end

    state_e            r_state;
    logic [LfsrDw-1:0] r_s;
    logic [FillW-1:0]  r_fill;
    logic [MatchW-1:0] r_match;
    logic [LossW-1:0]  r_loss;
    logic              r_err;
    logic [CntDw-1:0]  r_cnt;

    logic [LfsrDw-1:0] w_s_nxt;
    logic [FillW-1:0]  w_fill_nxt;
    logic [InDw-1:0]   w_mis;
    logic [InDw-1:0]   w_vld;
    logic [PopW-1:0]   w_pop;
    logic              w_any_err;
    logic              w_match;
    logic              w_s_zero;
    logic [MatchW-1:0] w_match_inc;
    logic [LossW-1:0]  w_loss_inc;
    logic [CntDw-1:0]  w_base;
    logic [SumW-1:0]   w_sum;
    logic [CntDw-1:0]  w_cnt_nxt;

    prim_lfsr_chk_step #(
        .LfsrDw (LfsrDw),
        .Taps   (Taps),
        .InDw   (InDw)
    ) u_step (
        .i_s    (r_s),
        .i_data (data_i),
        .i_mode (r_state),
        .i_fill (r_fill),
        .o_s    (w_s_nxt),
        .o_fill (w_fill_nxt),
        .o_mis  (w_mis),
        .o_vld  (w_vld)
    );

    // Count mismatched bits in the current beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < InDw; i++) begin
            w_pop = w_pop + PopW'(w_mis[i]);
        end
    end

    assign w_any_err   = |w_mis;
    assign w_match     = (|w_vld) && !w_any_err;
    assign w_s_zero    = (w_s_nxt == '0);
    assign w_match_inc = r_match + MatchW'(1);
    assign w_loss_inc  = r_loss + LossW'(1);

    // Clear happens before the beat's errors are added.
    assign w_base    = clr_i ? '0 : r_cnt;
    assign w_sum     = SumW'(w_base) + SumW'(w_pop);
    assign w_cnt_nxt = (|w_sum[SumW-1:CntDw]) ?
                       '1 : w_sum[CntDw-1:0];

    // Shadow state, FSM and lock/loss counters per valid beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SEARCH;
            r_s     <= '0;
            r_fill  <= '0;
            r_match <= '0;
            r_loss  <= '0;
        end else if (en_i) begin
            r_s <= w_s_nxt;
            unique case (r_state)
                SEARCH: begin
                    r_fill <= w_fill_nxt;
                    if (!w_match || w_s_zero) begin
                        r_match <= '0;
                    end else if (w_match_inc == MatchW'(LockCnt)) begin
                        r_state <= LOCKED;
                        r_match <= '0;
                        r_loss  <= '0;
                    end else begin
                        r_match <= w_match_inc;
                    end
                end
                LOCKED: begin
                    if (!w_any_err) begin
                        r_loss <= '0;
                    end else if (w_loss_inc == LossW'(LossCnt)) begin
                        r_state <= SEARCH;
                        r_fill  <= '0;
                        r_loss  <= '0;
                        r_match <= '0;
                    end else begin
                        r_loss <= w_loss_inc;
                    end
                end
            endcase
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= en_i && (r_state == LOCKED) && w_any_err;
            if (en_i && (r_state == LOCKED)) begin
                r_cnt <= w_cnt_nxt;
            end else if (clr_i) begin
                r_cnt <= '0;
            end
        end
    end

    assign locked_o  = (r_state == LOCKED);
    assign err_o     = r_err;
    assign err_cnt_o = r_cnt;

endmodule

// File: tb/tb_prim_lfsr_chk.sv
// tb_prim_lfsr_chk: directed checks of lock, error count,
// loss of lock, saturation, idle hold and async reset.
module tb_prim_lfsr_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_en, a_dat, a_clr, a_lock, a_err;
    logic [15:0] a_cnt;
    logic        b_en, b_dat, b_clr, b_lock, b_err;
    logic [3:0]  b_cnt;
    logic        c_en, c_clr, c_lock, c_err;
    logic [3:0]  c_dat;
    logic [15:0] c_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int a_pulses = 0;

    logic [6:0]  g7;
    logic [30:0] g31;

    prim_lfsr_chk u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(a_en),
        .data_i(a_dat), .clr_i(a_clr), .locked_o(a_lock),
        .err_o(a_err), .err_cnt_o(a_cnt)
    );

    prim_lfsr_chk #(.CntDw(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(b_en),
        .data_i(b_dat), .clr_i(b_clr), .locked_o(b_lock),
        .err_o(b_err), .err_cnt_o(b_cnt)
    );

    prim_lfsr_chk #(
        .LfsrDw(31), .Taps(31'h48000000), .InDw(4)
    ) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(c_en),
        .data_i(c_dat), .clr_i(c_clr), .locked_o(c_lock),
        .err_o(c_err), .err_cnt_o(c_cnt)
    );

    always @(negedge clk) begin
        if (a_err) a_pulses++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic adv7(output logic b);
        b  = ^(g7 & 7'h60);
        g7 = {g7[5:0], b};
    endtask

    task automatic adv31(output logic [3:0] d);
        logic b;
        for (int i = 3; i >= 0; i--) begin
            b    = ^(g31 & 31'h48000000);
            g31  = {g31[29:0], b};
            d[i] = b;
        end
    endtask

    task automatic beat_a(input logic d);
        a_en = 1'b1; a_dat = d;
        @(posedge clk); #1;
        a_en = 1'b0;
    endtask

    task automatic beat_b(input logic d, input logic clr);
        b_en = 1'b1; b_dat = d; b_clr = clr;
        @(posedge clk); #1;
        b_en = 1'b0; b_clr = 1'b0;
    endtask

    initial begin
        logic       bit1;
        logic [3:0] d4;
        int         p0;
        int         seen;
        int         act;

        rst_n = 1'b0;
        a_en = 0; a_dat = 0; a_clr = 0;
        b_en = 0; b_dat = 0; b_clr = 0;
        c_en = 0; c_dat = 0; c_clr = 0;

        // reset values
        #12;
        chk("rst_lock", 64'(a_lock), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // t1: lock on clean PRBS7 after 23 beats
        g7 = 7'h01;
        p0 = a_pulses;
        for (int i = 1; i <= 23; i++) begin
            adv7(bit1);
            beat_a(bit1);
            if (i == 22) chk("t1_lock22", 64'(a_lock), 64'd0);
        end
        chk("t1_lock23", 64'(a_lock), 64'd1);
        chk("t1_cnt", 64'(a_cnt), 64'd0);
        chk("t1_pulses", 64'(a_pulses - p0), 64'd0);

        // t2: single flipped bit while locked
        repeat (5) begin adv7(bit1); beat_a(bit1); end
        p0 = a_pulses;
        adv7(bit1);
        beat_a(~bit1);
        chk("t2_err", 64'(a_err), 64'd1);
        chk("t2_cnt", 64'(a_cnt), 64'd1);
        chk("t2_lock", 64'(a_lock), 64'd1);
        adv7(bit1);
        beat_a(bit1);
        chk("t2_err_next", 64'(a_err), 64'd0);
        repeat (20) begin adv7(bit1); beat_a(bit1); end
        chk("t2_cnt_after", 64'(a_cnt), 64'd1);
        chk("t2_lock_after", 64'(a_lock), 64'd1);
        chk("t2_pulses", 64'(a_pulses - p0), 64'd1);

        // t3: inverted stream loses lock, then relock
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("t3_clr", 64'(a_cnt), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            adv7(bit1);
            beat_a(~bit1);
            if (i == 3) chk("t3_lock3", 64'(a_lock), 64'd1);
        end
        chk("t3_lock4", 64'(a_lock), 64'd0);
        chk("t3_cnt", 64'(a_cnt), 64'd4);
        chk("t3_err", 64'(a_err), 64'd1);
        for (int i = 1; i <= 23; i++) begin
            adv7(bit1);
            beat_a(bit1);
            if (i == 22) chk("t3_relock22", 64'(a_lock), 64'd0);
        end
        chk("t3_relock23", 64'(a_lock), 64'd1);
        chk("t3_cnt_kept", 64'(a_cnt), 64'd4);

        // t4: all-zero input never locks
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            beat_a(1'b0);
            if (a_lock) seen++;
        end
        chk("t4_seen", 64'(seen), 64'd0);
        chk("t4_cnt", 64'(a_cnt), 64'd0);

        // t5: 4-bit counter saturates, clr with error beat
        g7 = 7'h01;
        repeat (23) begin adv7(bit1); beat_b(bit1, 1'b0); end
        chk("t5_lock", 64'(b_lock), 64'd1);
        for (int e = 1; e <= 20; e++) begin
            adv7(bit1);
            beat_b(~bit1, 1'b0);
            if (e == 14) chk("t5_cnt14", 64'(b_cnt), 64'd14);
            if (e == 15) chk("t5_cnt15", 64'(b_cnt), 64'd15);
            repeat (7) begin adv7(bit1); beat_b(bit1, 1'b0); end
        end
        chk("t5_sat", 64'(b_cnt), 64'd15);
        chk("t5_lock_kept", 64'(b_lock), 64'd1);
        adv7(bit1);
        beat_b(~bit1, 1'b1);
        chk("t5_clr_err", 64'(b_cnt), 64'd1);

        // t6: 4-bit beats, random idle cycles
        g31 = 31'd1;
        act = 0;
        for (int cyc = 0; cyc < 600 && act < 53; cyc++) begin
            c_en = ($urandom_range(0, 1) == 1);
            if (c_en) begin adv31(d4); act++; end
            else d4 = 4'($urandom);
            c_dat = d4;
            @(posedge clk); #1;
            c_en = 1'b0;
            chk("t6_lock", 64'(c_lock), 64'(act >= 23));
            chk("t6_err", 64'(c_err), 64'd0);
            chk("t6_cnt", 64'(c_cnt), 64'd0);
        end
        chk("t6_budget", 64'(act), 64'd53);

        // asynchronous reset mid-lock
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_lock", 64'(c_lock), 64'd0);
        chk("t6_rst_err", 64'(c_err), 64'd0);
        chk("t6_rst_cnt", 64'(c_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        act = 0;
        for (int cyc = 0; cyc < 600 && act < 30; cyc++) begin
            c_en = ($urandom_range(0, 1) == 1);
            if (c_en) begin adv31(d4); act++; end
            else d4 = 4'($urandom);
            c_dat = d4;
            @(posedge clk); #1;
            c_en = 1'b0;
            chk("t6_relock", 64'(c_lock), 64'(act >= 23));
            chk("t6_rerr", 64'(c_err), 64'd0);
        end
        chk("t6_rbudget", 64'(act), 64'd30);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
